// File: rtl/nes_bus_pkg.sv
// Shared 6502 bus types: loader states, open-bus default,
// opcode constants for building loader streams.
package nes_bus_pkg;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_ALO,
    LD_AHI,
    LD_LEN,
    LD_DATA
  } ld_state_t;

  localparam logic [7:0] OPEN_BUS_DEF = 8'h00;

  localparam logic [7:0] BRK      = 8'h00;
  localparam logic [7:0] ORA_ABS  = 8'h0D;
  localparam logic [7:0] CLC      = 8'h18;
  localparam logic [7:0] SEC      = 8'h38;
  localparam logic [7:0] ADC_ZP   = 8'h65;
  localparam logic [7:0] ADC_IMM  = 8'h69;
  localparam logic [7:0] ADC_ABS  = 8'h6D;
  localparam logic [7:0] ADC_INDY = 8'h71;
  localparam logic [7:0] ADC_ZPX  = 8'h75;
  localparam logic [7:0] STA_ABS  = 8'h8D;
  localparam logic [7:0] LDA_IMM  = 8'hA9;
  localparam logic [7:0] INY      = 8'hC8;
  localparam logic [7:0] INX      = 8'hE8;
  localparam logic [7:0] NOP      = 8'hEA;

  // True when addr falls in the 2^aw window holding base.
  function automatic logic win_hit(
    input logic [15:0] addr,
    input logic [15:0] base,
    input int unsigned aw
  );
    return (addr >> aw) == (base >> aw);
  endfunction

endpackage

// File: rtl/cpu_bus_mem_if.sv
// CPU bus and loader stream bundle for cpu_bus_mem.
// master = CPU/loader side, slave = memory side.
interface cpu_bus_mem_if;

  logic [15:0] Addr_bus;
  logic [7:0]  Data_wr;
  logic        we;
  logic [7:0]  Data_bus;
  logic        ld_start;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_ready;
  logic        cpu_hold;
  logic        ld_done;
  logic        ld_drop;
  logic        wp_err;

  modport master (
    output Addr_bus, Data_wr, we,
    output ld_start, ld_valid, ld_data,
    input  Data_bus, ld_ready, cpu_hold,
    input  ld_done, ld_drop, wp_err
  );

  modport slave (
    input  Addr_bus, Data_wr, we,
    input  ld_start, ld_valid, ld_data,
    output Data_bus, ld_ready, cpu_hold,
    output ld_done, ld_drop, wp_err
  );

endinterface

// File: rtl/cpu_bus_loader.sv
// Byte-stream program loader: ALO, AHI, LEN, then LEN data
// bytes (0 = 256). Holds the CPU in reset while active.
module cpu_bus_loader
  import nes_bus_pkg::*;
#(
  parameter int          MEM_AW   = 11,
  parameter int          WIN_AW   = 13,
  parameter logic [15:0] WIN_BASE = 16'h0000
) (
  input  logic              clk_ph1,
  input  logic              rst,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  output logic              ld_ready,
  output logic              cpu_hold,
  output logic              ld_done,
  output logic              ld_drop,
  output logic [MEM_AW-1:0] wr_idx,
  output logic [7:0]        wr_data,
  output logic              wr_en
);

  ld_state_t   state, state_n;
  logic [15:0] addr, addr_n;
  logic [8:0]  cnt, cnt_n;
  logic        done_n;
  logic        drop_n;
  logic        acc;
  logic        hit;

  assign ld_ready = (state != LD_IDLE);
  assign cpu_hold = (state != LD_IDLE);
  assign acc      = ld_valid && ld_ready;
  assign hit      = win_hit(addr, WIN_BASE, WIN_AW);

  assign wr_idx  = addr[MEM_AW-1:0];
  assign wr_data = ld_data;
  assign wr_en   = (state == LD_DATA) && acc && hit;

  // Next-state: header bytes fill address/count, data
  // bytes walk the address and count down to the end.
  always_comb begin
    state_n = state;
    addr_n  = addr;
    cnt_n   = cnt;
    done_n  = 1'b0;
    drop_n  = ld_drop;
    unique case (state)
      LD_IDLE: begin
        if (ld_start) state_n = LD_ALO;
      end
      LD_ALO: begin
        if (acc) begin
          addr_n[7:0] = ld_data;
          state_n     = LD_AHI;
        end
      end
      LD_AHI: begin
        if (acc) begin
          addr_n[15:8] = ld_data;
          state_n      = LD_LEN;
        end
      end
      LD_LEN: begin
        if (acc) begin
          cnt_n   = {ld_data == 8'd0, ld_data};
          state_n = LD_DATA;
        end
      end
      LD_DATA: begin
        if (acc) begin
          addr_n = addr + 16'd1;
          cnt_n  = cnt - 9'd1;
          if (!hit) drop_n = 1'b1;
          if (cnt == 9'd1) begin
            state_n = LD_IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = LD_IDLE;
    endcase
  end

  // Loader state registers; ld_drop stays set until rst.
  always_ff @(posedge clk_ph1 or posedge rst) begin
    if (rst) begin
      state   <= LD_IDLE;
      addr    <= 16'h0000;
      cnt     <= 9'd0;
      ld_done <= 1'b0;
      ld_drop <= 1'b0;
    end else begin
      state   <= state_n;
      addr    <= addr_n;
      cnt     <= cnt_n;
      ld_done <= done_n;
      ld_drop <= drop_n;
    end
  end

endmodule

// File: rtl/cpu_bus_mem.sv
// Mirrored RAM on the 6502 bus with program loader.
// Define CPU_BUS_MEM_WRPROT_EN to block CPU writes >= WP_BASE.
module cpu_bus_mem
  import nes_bus_pkg::*;
#(
  parameter int          MEM_AW   = 11,
  parameter int          WIN_AW   = 13,
  parameter logic [15:0] WIN_BASE = 16'h0000,
  parameter logic [7:0]  OPEN_BUS = OPEN_BUS_DEF,
  parameter logic [15:0] WP_BASE  = 16'h0100
) (
  input logic         clk_ph1,
  input logic         rst,
  cpu_bus_mem_if.slave bus
);

  logic [7:0]        mem [2**MEM_AW];
  logic              hit;
  logic [MEM_AW-1:0] idx;
  logic              cpu_we;
  logic [MEM_AW-1:0] lw_idx;
  logic [7:0]        lw_data;
  logic              lw_en;

  assign hit = win_hit(bus.Addr_bus, WIN_BASE, WIN_AW);
  assign idx = bus.Addr_bus[MEM_AW-1:0];

  cpu_bus_loader #(
    .MEM_AW   (MEM_AW),
    .WIN_AW   (WIN_AW),
    .WIN_BASE (WIN_BASE)
  ) u_loader (
    .clk_ph1  (clk_ph1),
    .rst      (rst),
    .ld_start (bus.ld_start),
    .ld_valid (bus.ld_valid),
    .ld_data  (bus.ld_data),
    .ld_ready (bus.ld_ready),
    .cpu_hold (bus.cpu_hold),
    .ld_done  (bus.ld_done),
    .ld_drop  (bus.ld_drop),
    .wr_idx   (lw_idx),
    .wr_data  (lw_data),
    .wr_en    (lw_en)
  );

`ifdef CPU_BUS_MEM_WRPROT_EN
  logic wp_hit;
  logic cpu_try;

  assign cpu_try = bus.we && hit && !bus.cpu_hold;
  assign wp_hit  = (bus.Addr_bus >= WP_BASE);
  assign cpu_we  = cpu_try && !wp_hit;

  // Sticky flag for CPU writes into the protected range.
  always_ff @(posedge clk_ph1 or posedge rst) begin
    if (rst) bus.wp_err <= 1'b0;
    else if (cpu_try && wp_hit) bus.wp_err <= 1'b1;
  end
`else
  assign cpu_we     = bus.we && hit && !bus.cpu_hold;
  assign bus.wp_err = 1'b0;
`endif

  // RAM write port; loader and CPU never overlap since
  // the CPU is locked out while the loader is active.
  always_ff @(posedge clk_ph1) begin
    if (lw_en) mem[lw_idx] <= lw_data;
    else if (cpu_we) mem[idx] <= bus.Data_wr;
  end

  // Registered read; sees the pre-write byte on collision.
  always_ff @(posedge clk_ph1 or posedge rst) begin
    if (rst) bus.Data_bus <= OPEN_BUS;
    else bus.Data_bus <= hit ? mem[idx] : OPEN_BUS;
  end

endmodule

// File: tb/tb_cpu_bus_mem.sv
// Directed self-checking bench for cpu_bus_mem.
// Inputs driven and outputs sampled on the falling edge.
module tb_cpu_bus_mem;
  import nes_bus_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   hold_cycles;
  int   done_cnt;

  cpu_bus_mem_if bus ();

  cpu_bus_mem dut (
    .clk_ph1 (clk),
    .rst     (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(
    input string       tag,
    input logic [15:0] obs,
    input logic [15:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (bus.cpu_hold === 1'b1) hold_cycles++;
    if (bus.ld_done === 1'b1) done_cnt++;
  endtask

  task automatic start();
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    chk("ld_ready", 16'(bus.ld_ready), 16'd1);
    bus.ld_valid = 1'b1;
    bus.ld_data  = b;
    tick();
    bus.ld_valid = 1'b0;
  endtask

  task automatic wr(
    input logic [15:0] a,
    input logic [7:0]  d
  );
    bus.Addr_bus = a;
    bus.Data_wr  = d;
    bus.we       = 1'b1;
    tick();
    bus.we = 1'b0;
  endtask

  task automatic rd(
    input string       tag,
    input logic [15:0] a,
    input logic [7:0]  exp
  );
    bus.Addr_bus = a;
    tick();
    chk(tag, 16'(bus.Data_bus), 16'(exp));
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    hold_cycles  = 0;
    done_cnt     = 0;
    rst          = 1'b1;
    bus.Addr_bus = 16'h0000;
    bus.Data_wr  = 8'h00;
    bus.we       = 1'b0;
    bus.ld_start = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_data  = 8'h00;
    tick();
    tick();
    chk("rst_data", 16'(bus.Data_bus), 16'h00);
    chk("rst_ready", 16'(bus.ld_ready), 16'd0);
    chk("rst_hold", 16'(bus.cpu_hold), 16'd0);
    chk("rst_done", 16'(bus.ld_done), 16'd0);
    chk("rst_drop", 16'(bus.ld_drop), 16'd0);
    chk("rst_wp", 16'(bus.wp_err), 16'd0);
    rst = 1'b0;
    tick();

    // Mirroring
    start();
    chk("mir_hold", 16'(bus.cpu_hold), 16'd1);
    send(8'h00);
    send(8'h00);
    send(8'h01);
    send(INY);
    chk("mir_done", 16'(bus.ld_done), 16'd1);
    chk("mir_hold0", 16'(bus.cpu_hold), 16'd0);
    rd("mir_0000", 16'h0000, 8'hC8);
    chk("mir_done0", 16'(bus.ld_done), 16'd0);
    rd("mir_0800", 16'h0800, 8'hC8);
    rd("mir_1800", 16'h1800, 8'hC8);
    rd("mir_2000", 16'h2000, 8'h00);

    // Record with a CPU write attempt mid-load
    hold_cycles = 0;
    done_cnt    = 0;
    start();
    send(8'h00);
    send(8'h02);
    send(8'h03);
    send(SEC);
    wr(16'h0200, 8'hFF);
    send(ADC_INDY);
    send(ORA_ABS);
    tick();
    tick();
    chk("rec_hold", 16'(hold_cycles), 16'd7);
    chk("rec_done", 16'(done_cnt), 16'd1);
    rd("rec_0200", 16'h0200, 8'h38);
    rd("rec_0201", 16'h0201, 8'h71);
    rd("rec_0202", 16'h0202, 8'h0D);

    // Count 0 (256 bytes) with address wrap
    hold_cycles = 0;
    done_cnt    = 0;
    start();
    send(8'hFF);
    send(8'hFF);
    send(8'h00);
    for (int i = 0; i < 256; i++) begin
      send(8'(i));
      if (i == 0)
        chk("wrap_drop", 16'(bus.ld_drop), 16'd1);
      if (i == 254)
        chk("wrap_hold", 16'(bus.cpu_hold), 16'd1);
    end
    chk("wrap_done", 16'(bus.ld_done), 16'd1);
    chk("wrap_hold0", 16'(bus.cpu_hold), 16'd0);
    chk("wrap_hcnt", 16'(hold_cycles), 16'd259);
    rd("wrap_0000", 16'h0000, 8'h01);
    rd("wrap_007F", 16'h007F, 8'h80);
    rd("wrap_00FE", 16'h00FE, 8'hFF);
    chk("wrap_dcnt", 16'(done_cnt), 16'd1);

    // Reset mid-load
    start();
    send(8'h00);
    send(8'h03);
    send(8'h05);
    send(8'h11);
    send(8'h22);
    rst = 1'b1;
    #1;
    chk("mrst_hold", 16'(bus.cpu_hold), 16'd0);
    chk("mrst_ready", 16'(bus.ld_ready), 16'd0);
    chk("mrst_drop", 16'(bus.ld_drop), 16'd0);
    tick();
    rst = 1'b0;
    chk("mrst_data", 16'(bus.Data_bus), 16'h00);
    rd("mrst_0300", 16'h0300, 8'h11);
    rd("mrst_0301", 16'h0301, 8'h22);
    start();
    chk("mrst_restart", 16'(bus.cpu_hold), 16'd1);
    send(8'h20);
    send(8'h03);
    send(8'h01);
    send(8'h33);
    chk("mrst_done", 16'(bus.ld_done), 16'd1);
    rd("mrst_0320", 16'h0320, 8'h33);

    // Write protect
    start();
    send(8'h05);
    send(8'h01);
    send(8'h01);
    send(8'h9A);
    rd("wp_pre", 16'h0105, 8'h9A);
    wr(16'h0105, 8'h55);
`ifdef CPU_BUS_MEM_WRPROT_EN
    rd("wp_0105", 16'h0105, 8'h9A);
    chk("wp_err", 16'(bus.wp_err), 16'd1);
`else
    rd("wp_0105", 16'h0105, 8'h55);
    chk("wp_err", 16'(bus.wp_err), 16'd0);
`endif
    wr(16'h00FF, 8'h66);
    rd("wp_00FF", 16'h00FF, 8'h66);

    // Same-cycle loader write / CPU read collision
    wr(16'h0010, 8'h5A);
    rd("col_pre", 16'h0010, 8'h5A);
    start();
    send(8'h10);
    send(8'h00);
    send(8'h01);
    bus.Addr_bus = 16'h0010;
    send(8'hAA);
    chk("col_old", 16'(bus.Data_bus), 16'h5A);
    tick();
    chk("col_new", 16'(bus.Data_bus), 16'hAA);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_bus_mem.md
# cpu_bus_mem

Parametrised memory model and program loader on the 6502 CPU address/data bus. It replaces hard-coded per-address program tables with a mirrored RAM window and a byte-stream loader that writes programs while holding the CPU in reset. It sits between the CPU core and the rest of the bus fabric, and is used by both benches and the synthesised NES top.

## Interface
- `MEM_AW`, 11: RAM index width; depth is 2^MEM_AW bytes.
- `WIN_AW`, 13: decode window width; the RAM mirrors every 2^MEM_AW bytes across a 2^WIN_AW window (MEM_AW ≤ WIN_AW ≤ 16).
- `WIN_BASE`, 16'h0000: window base; aligned to 2^WIN_AW.
- `OPEN_BUS`, 8'h00: read value for addresses outside the window.
- `WP_BASE`, 16'h0100: start of the write-protected range. Used only with the macro.
- `clk_ph1`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `Addr_bus`  in  16  CPU address.
- `Data_wr`  in  8  CPU write data.
- `we`  in  1  CPU write strobe.
- `Data_bus`  out  8  registered read data.
- `ld_start`  in  1  one-cycle pulse that begins a load record.
- `ld_valid`  in  1  loader byte valid.
- `ld_data`  in  8  loader byte.
- `ld_ready`  out  1  loader byte accepted when ld_valid && ld_ready.
- `cpu_hold`  out  1  drives the CPU reset while a load is in progress.
- `ld_done`  out  1  one-cycle pulse when the last data byte is written.
- `ld_drop`  out  1  sticky flag: a loader byte targeted an address outside the window.
- `wp_err`  out  1  sticky flag, macro only: the CPU wrote inside the protected range.

## Operation
- Address decode:
  - hit = (Addr_bus >> WIN_AW) == (WIN_BASE >> WIN_AW).
  - index = Addr_bus[MEM_AW-1:0].
- CPU read: every cycle, Data_bus <= hit ? mem[index] : OPEN_BUS.
- CPU write: when we && hit && !cpu_hold, mem[index] <= Data_wr.
  - When cpu_hold is high, CPU writes are ignored.
- Loader FSM states: IDLE, ALO, AHI, LEN, DATA.
  - IDLE -> ALO on ld_start. cpu_hold rises in the same edge.
  - Each accepted byte advances the FSM:
    - ALO latches the address low byte.
    - AHI latches the address high byte.
    - LEN latches the byte count, where 0 means 256.
  - DATA: each accepted byte writes mem at the current address. The address then increments mod 2^16 and the count decrements.
    - The address wraps 16'hFFFF -> 16'h0000.
    - A byte whose address misses the window is consumed, not written, and sets ld_drop.
  - DATA -> IDLE after the last byte. ld_done pulses and cpu_hold falls on that same edge.
- ld_ready is 1 in ALO, AHI, LEN and DATA; it is 0 in IDLE.
- ld_start is ignored in any state other than IDLE.
- If a loader write and a CPU read hit the same index in one cycle, the read returns the old byte (read-before-write).
- ld_drop and wp_err clear only on rst.

## Timing
- Read latency is 1 clk_ph1 cycle from Addr_bus to Data_bus.
- Write latency: the written value is visible to a read issued in the next cycle.
- Loader throughput is 1 byte per cycle. A record takes 3 + N accepted bytes.
- cpu_hold is high from the edge after ld_start up to and including the edge that writes the last byte.
- Reset values:
  - Data_bus = OPEN_BUS.
  - ld_ready, cpu_hold, ld_done, ld_drop and wp_err = 0.
  - FSM in IDLE; address and count registers = 0.
- rst asserted mid-load:
  - The FSM returns to IDLE and cpu_hold drops immediately (asynchronously).
  - Bytes already written stay in memory. The RAM array is never cleared by rst.

## Configuration
- `CPU_BUS_MEM_WRPROT_EN` defined:
  - CPU writes with hit && Addr_bus ≥ WP_BASE are blocked and set wp_err.
  - Loader writes are never blocked.
- Macro undefined:
  - No protection logic is built; wp_err is tied to 0.
  - All hit CPU writes proceed.

## Structure
- Shared package `nes_bus_pkg`:
  - Loader state enum.
  - The OPEN_BUS default.
  - Opcode localparams (ADC_*, INX/INY, SEC/CLC, ...) reused by benches to build loader streams.
- One sub-module, `cpu_bus_loader`: the FSM, address/count registers, ld_ready, cpu_hold, ld_done and ld_drop. It outputs a write port (addr, data, en) to the parent.
- Parent `cpu_bus_mem` holds the RAM array, decode, read register and CPU write/protect logic.

## Test plan
- Mirroring: load 8'hC8 at 16'h0000, then read 16'h0800 and 16'h1800 -> Data_bus = 8'hC8 one cycle after each address; read 16'h2000 -> OPEN_BUS (8'h00).
- Loader record: stream ld_start, then 00, 02, 03, 38, 71, 0D -> 16'h0200..0202 = 38, 71, 0D; cpu_hold is high for 7 cycles; ld_done pulses once; a CPU write to 16'h0200 during hold does not change the byte.
- Count of 0 with wrap: load at AHI:ALO = 16'hFFFF with LEN = 0 -> 256 bytes accepted; the first byte sets ld_drop; the remaining 255 land at 16'h0000..00FE (window base 0).
- Reset mid-load: assert rst after 2 data bytes -> cpu_hold = 0 immediately and the FSM is in IDLE; the 2 written bytes persist; a new ld_start is accepted after rst deasserts.
- Write protect, macro defined: a CPU write of 8'h55 to 16'h0105 -> byte unchanged and wp_err = 1; a write to 16'h00FF -> stored. Macro undefined: both writes are stored and wp_err stays 0.
- Same-cycle collision: loader writes 8'hAA to 16'h0010 while the CPU reads 16'h0010 -> old value returned; the next read returns 8'hAA.
